// File: rtl/grid_loader.sv
// grid_loader: streams ROWS*COLS two-bit cell values into the grid's per-cell
// load register, holds them static for HOLD_CYCLES so cells clocked by the
// divided clock can capture them, then releases the grid into run mode.
//
// Ports
//   clock       system clock, all state on its rising edge
//   reset       asynchronous, active-low
//   start       one-cycle request to begin a new fill (wins over everything)
//   inValid     producer has a cell value on inData
//   inData      cell value, row-major, cell 0 first
//   inReady     loader accepts inData this cycle (FILL only)
//   loadVals    per-cell load value, cell k at [2k+1:2k]
//   load        1 = cells run from neighbour sum, 0 = cells take loadVals
//   enTimeStep  time-step enable to the grid (RUN only)
//   busy        fill or hold in progress
//   done        one-cycle pulse on entry to RUN
module grid_loader #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     inValid,
  input  logic [1:0]               inData,
  output logic                     inReady,
  output logic [2*ROWS*COLS-1:0]   loadVals,
  output logic                     load,
  output logic                     enTimeStep,
  output logic                     busy,
  output logic                     done
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // A zero hold would skip the capture window entirely; keep at least one cycle.
  localparam int HC = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HW = (HC > 1) ? $clog2(HC) : 1;
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [HW-1:0] HLAST = HW'(HC - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, RUN} state_t;

  state_t        state, nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          wr;

  // inReady is the registered FILL flag, so it doubles as the accept gate.
  // A start in the same cycle discards the beat.
  assign wr = inValid & inReady & ~start;

  always_comb begin
    nxt      = state;
    idx_nxt  = idx;
    hcnt_nxt = hcnt;
    if (start) begin
      nxt      = FILL;
      idx_nxt  = '0;
      hcnt_nxt = '0;
    end else begin
      unique case (state)
        FILL: if (wr) begin
          if (idx == LAST) begin
            nxt      = HOLD;
            hcnt_nxt = '0;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
        HOLD: begin
          if (hcnt == HLAST) nxt = RUN;
          else               hcnt_nxt = hcnt + HW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      hcnt  <= '0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe without any input-to-output combinational path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inReady    <= 1'b0;
      load       <= 1'b0;
      enTimeStep <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      inReady    <= (nxt == FILL);
      load       <= (nxt == RUN);
      enTimeStep <= (nxt == RUN);
      busy       <= (nxt == FILL) || (nxt == HOLD);
      done       <= (nxt == RUN) && (state != RUN);
    end
  end

  // Slot write: only the addressed cell changes; old contents survive a
  // restart until they are overwritten.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loadVals <= '0;
    end else if (wr) begin
      for (int k = 0; k < N; k++)
        if (idx == IW'(k)) loadVals[2*k +: 2] <= inData;
    end
  end

endmodule

// File: tb/tb_grid_loader.sv
module tb_grid_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       inValid = 1'b0;
  logic [1:0] inData = '0;
  logic       inReady, load, enTimeStep, busy, done;
  logic [7:0] loadVals;

  int nvec = 0;
  int nbad = 0;

  grid_loader #(.ROWS(2), .COLS(2), .HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .inValid(inValid),
    .inData(inData), .inReady(inReady), .loadVals(loadVals), .load(load),
    .enTimeStep(enTimeStep), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st, vl;
    logic [1:0] d;
    logic [12:0] exp; // {inReady, load, enTimeStep, busy, done, loadVals}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, vl, input logic [1:0] d,
                     input logic rdy, ld, en, bsy, dn, input logic [7:0] lv);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d;
    v.exp = {rdy, ld, en, bsy, dn, lv};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = {inReady, load, enTimeStep, busy, done, loadVals};
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got rdy/ld/en/busy/done=%b lv=%h, want %b lv=%h",
               nm, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  initial begin
    //   st vl d   rdy ld en bsy dn lv
    // full fill 1,0,1,1 then hold and run
    add(1, 0, 0,  1, 0, 0, 1, 0, 8'h00);
    add(0, 1, 1,  1, 0, 0, 1, 0, 8'h01);
    add(0, 1, 0,  1, 0, 0, 1, 0, 8'h01);
    add(0, 1, 1,  1, 0, 0, 1, 0, 8'h11);
    add(0, 1, 1,  0, 0, 0, 1, 0, 8'h51);
    add(0, 1, 2,  0, 0, 0, 1, 0, 8'h51); // valid in HOLD ignored
    add(0, 0, 0,  0, 0, 0, 1, 0, 8'h51);
    add(0, 0, 0,  0, 0, 0, 1, 0, 8'h51);
    add(0, 0, 0,  0, 1, 1, 0, 1, 8'h51);
    add(0, 0, 0,  0, 1, 1, 0, 0, 8'h51);
    // start in RUN, then backpressured fill 2,3,0,2
    add(1, 0, 0,  1, 0, 0, 1, 0, 8'h51);
    add(0, 1, 2,  1, 0, 0, 1, 0, 8'h52);
    add(0, 0, 3,  1, 0, 0, 1, 0, 8'h52);
    add(0, 0, 1,  1, 0, 0, 1, 0, 8'h52);
    add(0, 1, 3,  1, 0, 0, 1, 0, 8'h5E);
    add(0, 0, 0,  1, 0, 0, 1, 0, 8'h5E);
    add(0, 1, 0,  1, 0, 0, 1, 0, 8'h4E);
    add(0, 1, 2,  0, 0, 0, 1, 0, 8'h8E);
    add(0, 0, 0,  0, 0, 0, 1, 0, 8'h8E);
    // start in HOLD, two beats, restart with a colliding beat, then 2,2,2,2
    add(1, 0, 0,  1, 0, 0, 1, 0, 8'h8E);
    add(0, 1, 1,  1, 0, 0, 1, 0, 8'h8D);
    add(0, 1, 1,  1, 0, 0, 1, 0, 8'h85);
    add(1, 1, 3,  1, 0, 0, 1, 0, 8'h85);
    add(0, 1, 2,  1, 0, 0, 1, 0, 8'h86);
    add(0, 1, 2,  1, 0, 0, 1, 0, 8'h8A);
    add(0, 1, 2,  1, 0, 0, 1, 0, 8'hAA);
    add(0, 1, 2,  0, 0, 0, 1, 0, 8'hAA);
    add(0, 0, 0,  0, 0, 0, 1, 0, 8'hAA);

    // reset held: all outputs zero
    #12;
    chk("reset", 13'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle", 13'h0);

    foreach (tbl[i]) begin
      start = tbl[i].st; inValid = tbl[i].vl; inData = tbl[i].d;
      @(posedge clock); #1;
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    start = 0; inValid = 0; inData = 0;

    // asynchronous reset between edges while in HOLD
    #3 reset = 1'b0;
    #1 chk("async_reset", 13'h0);
    #2 reset = 1'b1;

    // no activity without start, even with valid data offered
    inValid = 1'b1; inData = 2'd3;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk($sformatf("post_reset%0d", c), 13'h0);
    end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; inValid = 1'b0;
    chk("start_after_reset", {5'b10010, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/grid_loader.md
GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning grid rows.
REQ-002 SHALL have parameter COLS, default 8, meaning grid columns; N = ROWS*COLS cells.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4, meaning clock cycles loadVals is held static with load=0 after the last value, so cells clocked by the divided clock capture it.
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a new fill.
REQ-007 SHALL have port inValid  input  1  producer has a cell value on inData.
REQ-008 SHALL have port inData  input  2  cell value, row-major order, cell 0 first.
REQ-009 SHALL have port inReady  output  1  loader accepts inData this cycle.
REQ-010 SHALL have port loadVals  output  2*N  per-cell load value; cell k occupies bits [2k+1:2k].
REQ-011 SHALL have port load  output  1  1 = cells run from their neighbour sum; 0 = cells take loadVals.
REQ-012 SHALL have port enTimeStep  output  1  time-step enable to the grid.
REQ-013 SHALL have port busy  output  1  fill or hold in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on entry to RUN.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, HOLD, RUN.
REQ-016 SHALL go IDLE->FILL on start=1; idx cleared to 0.
REQ-017 SHALL assert inReady=1 only in FILL; a transfer occurs when inValid=1 and inReady=1 on the same rising edge.
REQ-018 SHALL, on a transfer, write inData into loadVals slot idx and increment idx; all other slots unchanged.
REQ-019 SHALL, on the transfer with idx=N-1, go to FILL->HOLD, reset the hold counter to 0, and deassert inReady from the next cycle.
REQ-020 SHALL, when inValid=0 in FILL, keep idx and loadVals unchanged (no timeout).
REQ-021 SHALL in HOLD count cycles; after HOLD_CYCLES cycles in HOLD go to RUN.
REQ-022 SHALL drive load=0 in IDLE, FILL and HOLD, and load=1 in RUN.
REQ-023 SHALL drive enTimeStep=1 only in RUN.
REQ-024 SHALL drive busy=1 exactly in FILL and HOLD.
REQ-025 SHALL pulse done=1 for exactly the first cycle in RUN.
REQ-026 SHALL keep loadVals stable in HOLD and RUN.
REQ-027 SHALL, on start=1 in RUN or HOLD, go to FILL with idx=0, load=0 the next cycle; loadVals retains the old contents until overwritten.
REQ-028 SHALL, on start=1 in FILL, restart with idx=0; a simultaneous transfer in that cycle is discarded (start wins).
REQ-029 SHALL size idx as ceil(log2(N)) bits (min 1) and never index beyond N-1.
REQ-030 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-031 SHALL on reset=0, immediately and independent of clock, force state=IDLE, idx=0, hold counter=0, loadVals=0, inReady=0, load=0, enTimeStep=0, busy=0, done=0.
REQ-032 SHALL leave IDLE only on a start edge sampled after reset deasserts; reset mid-FILL discards partial data.

Verification
REQ-033 Full fill: ROWS=COLS=2, start, 4 back-to-back values 1,0,1,1 -> loadVals=8'b01_01_00_01, busy 1 for 4+HOLD_CYCLES cycles, then load=1, enTimeStep=1, done pulses once.
REQ-034 Backpressure: inValid toggled 1,0,0,1,... during FILL -> idx advances only on valid cycles; final loadVals matches the sent sequence.
REQ-035 Restart mid-FILL: start after 2 of 4 values, then 4 values 2,2,2,2 -> loadVals=8'hAA; first 2 values discarded.
REQ-036 Start in RUN: load goes 0 the cycle after start, inReady=1, enTimeStep=0; old loadVals kept until overwritten.
REQ-037 Async reset mid-HOLD: reset=0 between edges -> all outputs 0 immediately; after release no activity until start.
REQ-038 Start with simultaneous valid in FILL -> that data not written, idx=0 next cycle.
